alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one registered-output ALU (1-cycle latency, 4-bit op code, two 32-bit operands) between two requesters, e.g. integer issue and address-gen ports.
- Arbitrates round-robin, drives and holds the ALU operand/op inputs, waits out the ALU's register stage, and returns a tagged result over a valid/ready response channel.
- Rejects op codes the ALU does not implement, so the ALU result register is never left stale.

Parameters:
- WIDTH, 32, operand/result width; must equal the ALU data width.
- ERR_DATA, 0, value driven on resp_data for rejected ops.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 handshake accepted this cycle.
- req0_op  in  4  op code: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl.
- req0_a  in  WIDTH  operand A.
- req0_b  in  WIDTH  operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as above, for requester 1.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  1  requester that owns the result.
- resp_data  out  WIDTH  result.
- resp_err  out  1  op code was illegal.
- alu_op  out  4  to ALU op select.
- alu_a  out  WIDTH  to ALU operand A.
- alu_b  out  WIDTH  to ALU operand B.
- alu_result  in  WIDTH  from ALU registered result.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async assert, sync deassert use): state IDLE; alu_op/alu_a/alu_b 0; resp_valid 0, resp_id 0, resp_err 0; last-grant pointer = 1, so requester 0 wins the first tie; busy 0.
- States: IDLE, EXEC, RESP.
- req*_ready is combinational. It is high only in IDLE, and only for the granted requester.
  - Grant rule: a single valid requester wins.
  - Both valid: the requester that is not the last-grant pointer wins.
- IDLE, handshake at edge E0:
  - Latch the granted op/a/b into alu_op/alu_a/alu_b.
  - Record owner in resp_id; update the pointer to the owner.
  - Legal op (0-6) -> EXEC.
  - Illegal op (7-15) -> RESP directly with resp_err=1; alu_* are not updated, and the ALU result register is not relied upon.
- EXEC: one cycle. The ALU registers its result at edge E1 -> RESP.
- RESP:
  - resp_valid=1; resp_data = resp_err ? ERR_DATA : alu_result.
  - alu_* are held constant throughout RESP, so alu_result stays stable across stall cycles.
  - On resp_valid && resp_ready -> IDLE.
- Latency: request handshake edge E0 -> resp_valid high after E1 (legal op) or after E0 (illegal op).
- Throughput: at most one op per 3 cycles. No new request is accepted while busy.
- resp_valid/resp_id/resp_data/resp_err must stay stable until the response handshake. Requester ready stays low during that time regardless of req_valid.
- Requests that drop req_valid before being granted are simply not served; no error.
- Reset asserted mid-operation: the in-flight op is discarded, no response is produced, and all outputs return to reset values immediately.
- All arithmetic is done by the ALU. The block performs no width extension except that noted under Optional Feature.

Optional Feature:
- Macro ALU_ARB_SHAMT_MASK_EN.
- Defined: for ops 5 and 6, alu_b = {zeros, req_b[4:0]}, so shift amounts wrap mod 32 (RISC-V semantics).
- Undefined: alu_b = req_b unmodified, so a shift by 32 or more yields 0.

Test Plan:
- Req0 op0, a=5, b=7, resp_ready=1 -> resp_valid two edges after handshake; resp_data=12, resp_id=0, resp_err=0; busy back to 0 next cycle.
- Req0 and req1 both valid every cycle, req0 op1 a=10 b=3, req1 op4 a=0xF0 b=0xFF, for four ops -> grants alternate 0,1,0,1; data 7, 0x0F, 7, 0x0F.
- Req1 op7 a=1 b=1 -> response one edge after handshake with resp_err=1, resp_data=ERR_DATA, resp_id=1; alu_op unchanged from the prior op.
- Req0 op2 a=0xFFFF0000 b=0x0FF00FF0, resp_ready low 5 cycles -> resp_valid and resp_data=0x0FF00000 stable throughout; req0_ready/req1_ready stay 0 until the handshake.
- Req0 op5 a=1 b=33 -> resp_data=2 with ALU_ARB_SHAMT_MASK_EN defined, 0 without.
- Assert rst_n low during EXEC -> resp_valid never rises; all outputs 0 asynchronously; first op after release is granted to requester 0 on a tie.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bundles the requester, response and ALU-side signals of the shared-ALU arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_data;
    logic             resp_err;

    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  resp_ready, alu_result,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_data, resp_err,
        output alu_op, alu_a, alu_b
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output resp_ready, alu_result,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_data, resp_err,
        input  alu_op, alu_a, alu_b
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one registered ALU between two requesters; ALU_ARB_SHAMT_MASK_EN wraps shift amounts mod 32.
// Latency: handshake edge -> resp_valid after 2 edges (legal op) or 1 edge (illegal op rejected locally).
// Backpressure: requesters see ready only in IDLE; the response and ALU inputs hold until resp_ready.
module alu_arbiter #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] ERR_DATA = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_MAX = 4'd6;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;

    state_t           state;
    logic             last_grant;
    logic             grant0;
    logic             grant1;
    logic             hs;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] sel_b_adj;

    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;
    logic             err_q;
    logic             vld_q;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
        grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
    end

    always_comb begin
        sel_op = grant0 ? bus.req0_op : bus.req1_op;
        sel_a  = grant0 ? bus.req0_a  : bus.req1_a;
        sel_b  = grant0 ? bus.req0_b  : bus.req1_b;
    end

`ifdef ALU_ARB_SHAMT_MASK_EN
    always_comb begin
        sel_b_adj = sel_b;
        if (sel_op == OP_SLL || sel_op == OP_SRL) begin
            sel_b_adj = {{(WIDTH-5){1'b0}}, sel_b[4:0]};
        end
    end
`else
    always_comb begin
        sel_b_adj = sel_b;
    end
`endif

    assign hs             = (state == IDLE) && (grant0 || grant1);
    assign bus.req0_ready = (state == IDLE) && grant0;
    assign bus.req1_ready = (state == IDLE) && grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            err_q      <= 1'b0;
            vld_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        id_q       <= grant1;
                        last_grant <= grant1;
                        if (sel_op <= OP_MAX) begin
                            op_q  <= sel_op;
                            a_q   <= sel_a;
                            b_q   <= sel_b_adj;
                            err_q <= 1'b0;
                            state <= EXEC;
                        end else begin
                            // Illegal op never touches the ALU; answer straight away.
                            err_q <= 1'b1;
                            vld_q <= 1'b1;
                            state <= RESP;
                        end
                    end
                end
                EXEC: begin
                    vld_q <= 1'b1;
                    state <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        vld_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.alu_op     = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.resp_valid = vld_q;
    assign bus.resp_id    = id_q;
    assign bus.resp_err   = err_q;
    // Gated so the data bus reads zero outside a response, including under reset.
    assign bus.resp_data  = !vld_q ? '0 : (err_q ? ERR_DATA : bus.alu_result);
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, hand sequences for stall/reset/alternation, and random transactions.
module tb_alu_arbiter;
    localparam int          W    = 32;
    localparam logic [31:0] ERRV = 32'hBAD0_0BAD;
`ifdef ALU_ARB_SHAMT_MASK_EN
    localparam bit MASK = 1'b1;
`else
    localparam bit MASK = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(W)) bus();

    alu_arbiter #(.WIDTH(W), .ERR_DATA(ERRV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    // The shared ALU: one register stage, raw shifts by the full operand B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.alu_result <= '0;
        else begin
            case (bus.alu_op)
                4'd0: bus.alu_result <= bus.alu_a + bus.alu_b;
                4'd1: bus.alu_result <= bus.alu_a - bus.alu_b;
                4'd2: bus.alu_result <= bus.alu_a & bus.alu_b;
                4'd3: bus.alu_result <= bus.alu_a | bus.alu_b;
                4'd4: bus.alu_result <= bus.alu_a ^ bus.alu_b;
                4'd5: bus.alu_result <= bus.alu_a << bus.alu_b;
                4'd6: bus.alu_result <= bus.alu_a >> bus.alu_b;
                default: bus.alu_result <= '0;
            endcase
        end
    end

    int          total = 0;
    int          bad   = 0;
    logic        last_model = 1'b1;
    logic [3:0]  last_legal_op = 4'd0;

    typedef struct {
        logic        v0;
        logic [3:0]  op0;
        logic [31:0] a0;
        logic [31:0] b0;
        logic        v1;
        logic [3:0]  op1;
        logic [31:0] a1;
        logic [31:0] b1;
        int          stall;
        logic        id;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint amt;
        amt = MASK ? longint'(b % 32) : longint'(b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return (amt >= 32) ? 32'd0 : 32'(a * (64'd1 << amt));
            4'd6: return (amt >= 32) ? 32'd0 : 32'(a / (64'd1 << amt));
            default: return ERRV;
        endcase
    endfunction

    function automatic logic pick(input logic v0, input logic v1, input logic last);
        if (v0 && !v1) return 1'b0;
        if (v1 && !v0) return 1'b1;
        return (last == 1'b0) ? 1'b1 : 1'b0;
    endfunction

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.resp_ready = 1'b0;
    endtask

    task automatic txn(input vec_t t);
        int         lat;
        logic       got;
        logic [3:0] wop;
        @(negedge clk);
        bus.req0_valid = t.v0; bus.req0_op = t.op0; bus.req0_a = t.a0; bus.req0_b = t.b0;
        bus.req1_valid = t.v1; bus.req1_op = t.op1; bus.req1_a = t.a1; bus.req1_b = t.b1;
        bus.resp_ready = 1'b0;
        #1;
        chk("grant0", 32'(bus.req0_ready), 32'(t.id == 1'b0));
        chk("grant1", 32'(bus.req1_ready), 32'(t.id == 1'b1));
        @(posedge clk);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        lat = 1;
        got = bus.resp_valid;
        while (!got && lat < 6) begin
            @(negedge clk);
            lat++;
            got = bus.resp_valid;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL resp_timeout: got no resp_valid want resp_valid within 6 cycles");
            idle_inputs();
            return;
        end
        chk("latency", 32'(lat), t.err ? 32'd1 : 32'd2);
        chk("resp_id", 32'(bus.resp_id), 32'(t.id));
        chk("resp_data", bus.resp_data, t.data);
        chk("resp_err", 32'(bus.resp_err), 32'(t.err));
        wop = t.id ? t.op1 : t.op0;
        if (!t.err) last_legal_op = wop;
        chk("alu_op_hold", 32'(bus.alu_op), 32'(last_legal_op));
        for (int k = 0; k < t.stall; k++) begin
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
            #1;
            chk("stall_rdy0", 32'(bus.req0_ready), 32'd0);
            chk("stall_rdy1", 32'(bus.req1_ready), 32'd0);
            chk("stall_vld", 32'(bus.resp_valid), 32'd1);
            chk("stall_data", bus.resp_data, t.data);
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("busy_after", 32'(busy), 32'd0);
        chk("vld_after", 32'(bus.resp_valid), 32'd0);
        last_model = t.id;
    endtask

    initial begin
        vec_t        r;
        int          n;
        logic        exp_ids[4];
        logic [31:0] exp_dat[4];

        idle_inputs();
        bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;

        // Expected values assume the pointer starts at 1 after reset and follows each winner.
        tbl[0] = '{1'b1, 4'd0, 32'd5, 32'd7,              1'b0, 4'd0, 32'd0, 32'd0,         0, 1'b0, 32'd12, 1'b0};
        tbl[1] = '{1'b0, 4'd0, 32'd0, 32'd0,              1'b1, 4'd7, 32'd1, 32'd1,         0, 1'b1, ERRV, 1'b1};
        tbl[2] = '{1'b1, 4'd1, 32'd10, 32'd3,             1'b1, 4'd4, 32'hF0, 32'hFF,       0, 1'b0, 32'd7, 1'b0};
        tbl[3] = '{1'b1, 4'd1, 32'd10, 32'd3,             1'b1, 4'd4, 32'hF0, 32'hFF,       1, 1'b1, 32'h0F, 1'b0};
        tbl[4] = '{1'b1, 4'd5, 32'd1, 32'd33,             1'b0, 4'd0, 32'd0, 32'd0,         0, 1'b0, MASK ? 32'd2 : 32'd0, 1'b0};
        tbl[5] = '{1'b0, 4'd0, 32'd0, 32'd0,              1'b1, 4'd6, 32'h8000_0000, 32'd31, 0, 1'b1, 32'd1, 1'b0};
        tbl[6] = '{1'b1, 4'd2, 32'hFFFF_0000, 32'h0FF0_0FF0, 1'b0, 4'd0, 32'd0, 32'd0,      5, 1'b0, 32'h0FF0_0000, 1'b0};
        tbl[7] = '{1'b1, 4'd15, 32'd1, 32'd1,             1'b1, 4'd3, 32'h0F0, 32'h00F,     2, 1'b1, 32'hFF, 1'b0};
        tbl[8] = '{1'b1, 4'd9, 32'd4, 32'd4,              1'b1, 4'd0, 32'd1, 32'd1,         1, 1'b0, ERRV, 1'b1};
        tbl[9] = '{1'b1, 4'd6, 32'h1234, 32'd32,          1'b0, 4'd0, 32'd0, 32'd0,         0, 1'b0, MASK ? 32'h1234 : 32'd0, 1'b0};

        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vld", 32'(bus.resp_valid), 32'd0);
        chk("rst_id", 32'(bus.resp_id), 32'd0);
        chk("rst_err", 32'(bus.resp_err), 32'd0);
        chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_alu_b", bus.alu_b, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) txn(tbl[i]);

        // Reset during EXEC discards the op.
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_op = 4'd0; bus.req0_a = 32'd1; bus.req0_b = 32'd2;
        @(posedge clk);
        #2;
        bus.req0_valid = 1'b0;
        chk("exec_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_vld", 32'(bus.resp_valid), 32'd0);
        chk("arst_alu_op", 32'(bus.alu_op), 32'd0);
        chk("arst_alu_a", bus.alu_a, 32'd0);
        chk("arst_alu_b", bus.alu_b, 32'd0);
        chk("arst_data", bus.resp_data, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("arst_hold_vld", 32'(bus.resp_valid), 32'd0);
        end
        rst_n = 1'b1;
        last_model = 1'b1;
        last_legal_op = 4'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_vld", 32'(bus.resp_valid), 32'd0);
        end

        // Both requesters valid every cycle: grants alternate starting at 0.
        exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_dat = '{32'd7, 32'h0F, 32'd7, 32'h0F};
        bus.req0_valid = 1'b1; bus.req0_op = 4'd1; bus.req0_a = 32'd10;  bus.req0_b = 32'd3;
        bus.req1_valid = 1'b1; bus.req1_op = 4'd4; bus.req1_a = 32'hF0;  bus.req1_b = 32'hFF;
        bus.resp_ready = 1'b1;
        #1;
        chk("tie_rdy0", 32'(bus.req0_ready), 32'd1);
        chk("tie_rdy1", 32'(bus.req1_ready), 32'd0);
        n = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            if (busy) begin
                chk("busy_rdy", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
            end
            if (bus.resp_valid) begin
                chk("alt_id", 32'(bus.resp_id), 32'(exp_ids[n]));
                chk("alt_data", bus.resp_data, exp_dat[n]);
                last_model = exp_ids[n];
                n++;
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        if (n < 4) begin
            total++; bad++;
            $display("FAIL alt_timeout: got %0d responses want 4", n);
        end
        @(negedge clk);
        bus.resp_ready = 1'b0;
        last_legal_op = 4'd4;

        for (int i = 0; i < 150; i++) begin
            int sel;
            sel     = $urandom_range(1, 3);
            r.v0    = sel[0];
            r.v1    = sel[1];
            r.op0   = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(0, 15));
            r.op1   = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(0, 15));
            r.a0    = $urandom;
            r.a1    = $urandom;
            r.b0    = $urandom_range(0, 1) ? 32'($urandom_range(0, 40)) : $urandom;
            r.b1    = $urandom_range(0, 1) ? 32'($urandom_range(0, 40)) : $urandom;
            r.stall = $urandom_range(0, 3);
            r.id    = pick(r.v0, r.v1, last_model);
            r.err   = (r.id ? r.op1 : r.op0) > 4'd6;
            r.data  = r.err ? ERRV : (r.id ? ref_res(r.op1, r.a1, r.b1) : ref_res(r.op0, r.a0, r.b0));
            txn(r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
